// File: rtl/cpu_step_ctrl.sv
// Execution controller for the single-cycle MIPS core: debounces step/run buttons and
// generates the PC enable for single-step, divided free-run and PC-breakpoint halt.
module cpu_step_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int RUN_DIV    = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pcdata,
    output logic        we,
    output logic        running,
    output logic        halted,
    output logic [15:0] step_cnt
);
    localparam int NUM_BTN = 2;
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, STEP, RUN, HALT} state_t;

    logic [NUM_BTN-1:0]         btn_raw, s1, s2, deb, deb_d, press;
    logic [NUM_BTN-1:0][CW-1:0] deb_cnt;
    logic                       run_p, step_p;

    state_t        state, state_n;
    logic [DW-1:0] div;
    logic          div_last, skip_bp, bp_hit;

    // lane 0 = step, lane 1 = run; both lanes share the same conditioning path
    assign btn_raw = {btn_run, btn_step};

    always_ff @(posedge clk) begin
        if (clr) begin
            s1      <= '0;
            s2      <= '0;
            deb     <= '0;
            deb_d   <= '0;
            deb_cnt <= '0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (s2[i] != deb[i]) begin
                    if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        deb[i]     <= s2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign press  = deb & ~deb_d;
    assign run_p  = press[1];
    assign step_p = press[0];

    assign div_last = (div == DW'(RUN_DIV - 1));
    assign bp_hit   = bp_en && (pcdata == bp_addr) && div_last && !skip_bp;

    // run is tested first everywhere, so a coincident step pulse is dropped
    always_comb begin
        state_n = state;
        we      = 1'b0;
        case (state)
            IDLE: begin
                if (run_p)       state_n = RUN;
                else if (step_p) state_n = STEP;
            end
            STEP: begin
                we      = 1'b1;
                state_n = IDLE;
            end
            RUN: begin
                if (run_p)       state_n = IDLE;
                else if (bp_hit) state_n = HALT;
                else             we = div_last;
            end
            HALT: begin
                if (run_p)       state_n = RUN;
                else if (step_p) state_n = STEP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            div      <= '0;
            skip_bp  <= 1'b0;
            running  <= 1'b0;
            halted   <= 1'b0;
            step_cnt <= '0;
        end else begin
            state   <= state_n;
            running <= (state_n == RUN);
            halted  <= (state_n == HALT);
            if (state == RUN && state_n == RUN)
                div <= div_last ? '0 : div + DW'(1);
            else
                div <= '0;
            // resuming from a breakpoint must not re-hit the same PC before it moves
            if (state != RUN && state_n == RUN)
                skip_bp <= (state == HALT);
            else if (state == RUN && we)
                skip_bp <= 1'b0;
            if (we)
                step_cnt <= step_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: expected enable cycles are queued when buttons are
// driven and popped by a monitor whenever the DUT raises we.
module tb_cpu_step_ctrl;
    logic        clk = 1'b0;
    logic        clr, btn_step, btn_run, bp_en, pc_clr;
    logic [31:0] bp_addr, pc;
    logic        we, running, halted;
    logic [15:0] step_cnt;
    logic        b2_step, b2_run, we2, running2, halted2;
    logic [15:0] step_cnt2;
    logic [31:0] zero32 = '0;
    logic        zero1 = 1'b0;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    int sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (pc_clr)  pc <= '0;
        else if (we) pc <= pc + 32'd4;
    end

    cpu_step_ctrl #(.DEB_CYCLES(4), .RUN_DIV(4)) dut (
        .clk(clk), .clr(clr), .btn_step(btn_step), .btn_run(btn_run),
        .bp_en(bp_en), .bp_addr(bp_addr), .pcdata(pc),
        .we(we), .running(running), .halted(halted), .step_cnt(step_cnt)
    );

    cpu_step_ctrl #(.DEB_CYCLES(1), .RUN_DIV(1)) dut2 (
        .clk(clk), .clr(clr), .btn_step(b2_step), .btn_run(b2_run),
        .bp_en(zero1), .bp_addr(zero32), .pcdata(zero32),
        .we(we2), .running(running2), .halted(halted2), .step_cnt(step_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic push_we(input int first, input int last_excl, input int period);
        for (int t = first; t < last_excl; t += period) begin
            sb.push_back(t);
            exp_cnt++;
        end
    endtask

    // every we pulse must match the next queued cycle; -1 marks an unexpected enable
    always @(negedge clk) begin
        if (we === 1'b1) begin
            int e;
            e = (sb.size() != 0) ? sb.pop_front() : -1;
            chk("we_cycle", cyc, e);
        end
    end

    initial begin
        int n, m, k;
        clr = 1'b1; btn_step = 1'b1; btn_run = 1'b1; bp_en = 1'b0; bp_addr = '0;
        pc_clr = 1'b1; b2_step = 1'b0; b2_run = 1'b0;

        // reset held with buttons high
        wait_cyc(2);
        chk("rst_we", we, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_step_cnt", step_cnt, 0);
        clr = 1'b0; btn_step = 1'b0; btn_run = 1'b0; pc_clr = 1'b0;
        wait_cyc(100);
        chk("idle_step_cnt", step_cnt, 0);

        // single step: enable 7 cycles after the first high sample
        n = cyc; btn_step = 1'b1;
        push_we(n + 7, n + 8, 1);
        wait_cyc(20); btn_step = 1'b0;
        wait_cyc(10);
        chk("step_cnt_step", step_cnt, exp_cnt);
        chk("step_running", running, 0);

        // bounce shorter than the debounce window
        btn_step = 1'b1; wait_cyc(1); btn_step = 1'b0; wait_cyc(1);
        btn_step = 1'b1; wait_cyc(1); btn_step = 1'b0; wait_cyc(20);
        chk("bounce_step_cnt", step_cnt, exp_cnt);

        // run then stop; the enable coinciding with the stop pulse is suppressed
        n = cyc; btn_run = 1'b1;
        push_we(n + 10, n + 46, 4);
        wait_cyc(8);
        chk("run_running", running, 1);
        wait_cyc(2); btn_run = 1'b0;
        wait_cyc(30); btn_run = 1'b1;
        wait_cyc(7);
        chk("stop_running", running, 0);
        btn_run = 1'b0;
        wait_cyc(10);
        chk("run_step_cnt", step_cnt, exp_cnt);

        // breakpoint at 0x0C with PC starting from 0
        pc_clr = 1'b1; wait_cyc(1); pc_clr = 1'b0;
        bp_en = 1'b1; bp_addr = 32'h0000_000C;
        n = cyc; btn_run = 1'b1;
        push_we(n + 10, n + 22, 4);
        wait_cyc(10); btn_run = 1'b0;
        wait_cyc(20);
        chk("bp_halted", halted, 1);
        chk("bp_running", running, 0);
        chk("bp_pc", pc, 32'h0000_000C);
        chk("bp_step_cnt", step_cnt, exp_cnt);
        bp_addr = 32'h0000_0040; wait_cyc(3);
        chk("bp_addr_change_halted", halted, 1);
        bp_addr = 32'h0000_000C; wait_cyc(3);
        m = cyc; btn_run = 1'b1;
        push_we(m + 10, m + 26, 4);
        wait_cyc(10); btn_run = 1'b0;
        wait_cyc(10); btn_run = 1'b1;
        wait_cyc(10); btn_run = 1'b0;
        chk("resume_halted", halted, 0);
        chk("resume_pc", pc, 32'h0000_001C);
        wait_cyc(10);
        bp_en = 1'b0;

        // simultaneous run and step from IDLE: run wins
        n = cyc; btn_run = 1'b1; btn_step = 1'b1;
        push_we(n + 10, n + 26, 4);
        wait_cyc(8);
        chk("prio_running", running, 1);
        chk("prio_halted", halted, 0);
        wait_cyc(2); btn_run = 1'b0; btn_step = 1'b0;
        wait_cyc(10); btn_run = 1'b1;
        wait_cyc(10); btn_run = 1'b0;
        chk("prio_stop_running", running, 0);
        wait_cyc(10);
        chk("prio_step_cnt", step_cnt, exp_cnt);

        // reset in the middle of RUN: no further enables
        n = cyc; btn_run = 1'b1;
        push_we(n + 10, n + 11, 1);
        wait_cyc(12); clr = 1'b1; btn_run = 1'b0;
        wait_cyc(1); clr = 1'b0;
        exp_cnt = 0;
        chk("midrun_rst_running", running, 0);
        chk("midrun_rst_step_cnt", step_cnt, 0);
        wait_cyc(20);
        chk("midrun_after_step_cnt", step_cnt, exp_cnt);

        // step_cnt wrap on the every-cycle instance
        b2_run = 1'b1;
        k = 0;
        while (step_cnt2 !== 16'hFFFF && k < 70000) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_reach_ffff", step_cnt2, 32'h0000_FFFF);
        chk("wrap_we2", we2, 1);
        wait_cyc(1);
        chk("wrap_zero", step_cnt2, 0);
        chk("wrap_running2", running2, 1);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
